mem_byte_sequencer: RTL and testbench
=====================================

# mem_byte_sequencer

Multi-cycle data-memory sequencer in the MEM stage, between the EX/MEM pipeline register and the byte-wide data RAM (256 x 8). Every load/store request becomes one (byte) or four (word) single-byte RAM accesses. While an access is in progress it raises a stall to the hazard/forwarding logic. It returns the assembled 32-bit load value to the MEM/WB path.

## Interface
Parameters:
- ADDR_W, 8, byte-address width (RAM depth 2^ADDR_W)

Ports:
- clk  in  1  pipeline clock, rising-edge
- R  in  1  reset, asynchronous, active-low (0 = reset)
- req_valid  in  1  MEM-stage memory enable (load or store present in EX/MEM)
- req_rw  in  1  0 = read (load), 1 = write (store)
- req_size  in  1  0 = byte, 1 = word
- req_addr  in  ADDR_W  effective address from EX/MEM
- req_wdata  in  32  store data (MEM-stage Pd)
- mem_e  out  1  RAM enable, high only in XFER
- mem_rw  out  1  RAM write strobe (mirrors captured req_rw in XFER, else 0)
- mem_addr  out  ADDR_W  RAM byte address
- mem_wdata  out  8  RAM byte write data
- mem_rdata  in  8  RAM byte read data, combinational from mem_addr
- busy  out  1  stall: freezes PC, IF/ID, ID/EX, EX/MEM
- done  out  1  one-cycle pulse: access complete, rdata valid
- err  out  1  one-cycle pulse: misaligned word request rejected
- rdata  out  32  load result (byte zero-extended)

## Operation
- States: IDLE, XFER, DONE. Internal: 2-bit byte counter cnt, captured addr/wdata/rw/size, 32-bit read accumulator.
- IDLE, req_valid=0: all strobes 0, stay.
- IDLE, req_valid=1, req_size=1, req_addr[1:0]!=0: no access. err=1, done=1, rdata<=0. Stay IDLE.
- IDLE, req_valid=1, otherwise: capture request, cnt<=0, accumulator<=0, go XFER.
- XFER: mem_e=1, mem_addr=base+cnt (mod 2^ADDR_W), mem_rw=captured rw.
  - Big-endian: byte at base is bits [31:24] of the word.
  - Write, word: mem_wdata=wdata[31-8*cnt -: 8]. Write, byte: mem_wdata=wdata[7:0].
  - Read: accumulator<={accumulator[23:0], mem_rdata} each XFER cycle.
  - Last byte (byte size: cnt=0; word: cnt=3): go DONE. Otherwise cnt<=cnt+1.
- DONE: done=1, busy=0. rdata = accumulator for reads (byte reads are thus {24'b0, byte}); rdata unchanged for writes. Go IDLE unconditionally.
- Outside XFER: mem_wdata=0, mem_addr=0.
- rdata holds its value until the next read DONE or misaligned err.
- busy = (IDLE & req_valid & aligned) | XFER. Zero in DONE, so the pipeline advances on the DONE edge.

## Timing
- Reset (R=0, any state, including mid-XFER): state=IDLE, cnt=0, rdata=0, accumulator=0. All outputs 0 immediately (asynchronous). No further RAM strobes after R falls.
- Request accepted in cycle T (IDLE). Byte: XFER at T+1, DONE at T+2, busy high T..T+1. Word: XFER at T+1..T+4, DONE at T+5, busy high T..T+4.
- Misaligned word: err/done in cycle T, busy low; zero stall cycles.
- Request still asserted in DONE is ignored. The next request is sampled in IDLE at DONE+1, so back-to-back requests cost one extra idle-sampling cycle each.
- Writes take effect at the RAM edge of each XFER cycle. Read data is sampled at the end of each XFER cycle.
- Address arithmetic wraps modulo 2^ADDR_W. Aligned word at 8'hFC covers FC..FF with no wrap.

## Test plan
- Reset: hold R=0 three cycles with req_valid=1 -> busy=0, done=0, mem_e=0, rdata=0. Release R -> accepted next edge.
- Word store, addr=8'h10, wdata=32'hDEADBEEF -> four XFER cycles writing 10:DE, 11:AD, 12:BE, 13:EF. busy high 5 cycles, done at cycle 6.
- Word load, addr=8'h10 after the store -> rdata=32'hDEADBEEF on the done cycle. mem_addr sequence 10,11,12,13.
- Byte load, addr=8'h12 -> one XFER; rdata=32'h000000BE, done 2 cycles after accept. Byte store of 32'h12345677 to 8'h20 -> RAM[20]=77.
- Misaligned word load, addr=8'h11 -> err=1 and done=1 the same cycle, busy never high, mem_e never high, rdata=0.
- Reset mid-word-store after second byte -> RAM[base+2..3] untouched, state IDLE, outputs 0. A fresh request after R=1 completes normally.

Source files
------------

// File: rtl/mem_byte_sequencer.sv
// Byte-serial data-memory sequencer for the MEM stage: turns byte/word load/store
// requests into single-byte RAM accesses, stalls the pipeline meanwhile, assembles loads.
module mem_byte_sequencer #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              R,
    input  logic              req_valid,
    input  logic              req_rw,
    input  logic              req_size,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              mem_e,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [31:0]       rdata
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_XFER = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              rw_q, rw_d;
    logic              size_q, size_d;
    logic [31:0]       acc_q, acc_d;
    logic [31:0]       rdata_q, rdata_d;

    logic idle_req;
    logic misaligned;
    logic in_xfer;
    logic last_byte;
    logic [7:0] word_byte;

    // Request-derived strobes are gated by R so every output drops the instant reset asserts.
    assign idle_req   = R && (state_q == S_IDLE) && req_valid;
    assign misaligned = req_size && (req_addr[1:0] != 2'b00);
    assign in_xfer    = (state_q == S_XFER);
    assign last_byte  = size_q ? (cnt_q == 2'd3) : 1'b1;

    always_comb begin
        word_byte = 8'h00;
        case (cnt_q)
            2'd0:    word_byte = wdata_q[31:24];
            2'd1:    word_byte = wdata_q[23:16];
            2'd2:    word_byte = wdata_q[15:8];
            default: word_byte = wdata_q[7:0];
        endcase
    end

    always_comb begin
        mem_e     = in_xfer;
        mem_rw    = in_xfer && rw_q;
        mem_addr  = in_xfer ? (addr_q + ADDR_W'(cnt_q)) : '0;
        mem_wdata = (in_xfer && rw_q) ? (size_q ? word_byte : wdata_q[7:0]) : 8'h00;
        busy      = (idle_req && !misaligned) || in_xfer;
        err       = idle_req && misaligned;
        done      = err || (state_q == S_DONE);
        if (err)
            rdata = 32'h0;
        else if ((state_q == S_DONE) && !rw_q)
            rdata = acc_q;
        else
            rdata = rdata_q;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rw_d    = rw_q;
        size_d  = size_q;
        acc_d   = acc_q;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    if (misaligned) begin
                        rdata_d = 32'h0;
                    end else begin
                        addr_d  = req_addr;
                        wdata_d = req_wdata;
                        rw_d    = req_rw;
                        size_d  = req_size;
                        cnt_d   = 2'd0;
                        acc_d   = 32'h0;
                        state_d = S_XFER;
                    end
                end
            end
            S_XFER: begin
                // Big-endian: first byte fetched ends up in the top byte after four shifts.
                if (!rw_q)
                    acc_d = {acc_q[23:0], mem_rdata};
                if (last_byte)
                    state_d = S_DONE;
                else
                    cnt_d = cnt_q + 2'd1;
            end
            S_DONE: begin
                if (!rw_q)
                    rdata_d = acc_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge R) begin
        if (!R) begin
            state_q <= S_IDLE;
            cnt_q   <= 2'd0;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            rw_q    <= 1'b0;
            size_q  <= 1'b0;
            acc_q   <= 32'h0;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rw_q    <= rw_d;
            size_q  <= size_d;
            acc_q   <= acc_d;
            rdata_q <= rdata_d;
        end
    end
endmodule

// File: tb/tb_mem_byte_sequencer.sv
// Directed bench for mem_byte_sequencer with a 256x8 RAM model behind the byte port.
module tb_mem_byte_sequencer;
    logic        clk = 1'b0;
    logic        R;
    logic        req_valid, req_rw, req_size;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;
    logic        mem_e, mem_rw;
    logic [7:0]  mem_addr, mem_wdata, mem_rdata;
    logic        busy, done, err;
    logic [31:0] rdata;

    logic [7:0] ram [0:255];
    int checks = 0;
    int errors = 0;

    mem_byte_sequencer #(.ADDR_W(8)) dut (
        .clk(clk), .R(R),
        .req_valid(req_valid), .req_rw(req_rw), .req_size(req_size),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .mem_e(mem_e), .mem_rw(mem_rw), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy), .done(done), .err(err), .rdata(rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = ram[mem_addr];
    always @(posedge clk)
        if (mem_e && mem_rw) ram[mem_addr] <= mem_wdata;

    task automatic drive_req(input logic rw, input logic size, input logic [7:0] addr,
                             input logic [31:0] wd);
        req_valid = 1'b1; req_rw = rw; req_size = size; req_addr = addr; req_wdata = wd;
    endtask

    task automatic test_reset();
        R = 1'b0;
        drive_req(1'b0, 1'b1, 8'h00, 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            checks++;
            if (busy !== 1'b0 || done !== 1'b0 || mem_e !== 1'b0 || rdata !== 32'h0) begin
                errors++;
                $display("FAIL reset_outputs: busy=%b done=%b mem_e=%b rdata=%h, want all 0",
                         busy, done, mem_e, rdata);
            end
        end
        R = 1'b1; #1;
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL reset_release_busy: got %b want 1", busy);
        end
        @(negedge clk); req_valid = 1'b0; #1;
        checks++;
        if (mem_e !== 1'b1 || mem_addr !== 8'h00) begin
            errors++; $display("FAIL reset_release_accept: mem_e=%b addr=%h want 1/00", mem_e, mem_addr);
        end
        repeat (4) @(negedge clk);
        #1;
        checks++;
        if (done !== 1'b1) begin
            errors++; $display("FAIL reset_release_done: got %b want 1", done);
        end
        @(negedge clk);
    endtask

    task automatic test_word_store();
        logic [31:0] wd = 32'hDEADBEEF;
        drive_req(1'b1, 1'b1, 8'h10, wd); #1;
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL wstore_busy_accept: got %b want 1", busy);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k == 0) req_valid = 1'b0;
            #1;
            checks++;
            if (mem_e !== 1'b1 || mem_rw !== 1'b1 || busy !== 1'b1 || done !== 1'b0 ||
                mem_addr !== 8'(8'h10 + k) || mem_wdata !== wd[31-8*k -: 8]) begin
                errors++;
                $display("FAIL wstore_xfer%0d: e=%b rw=%b busy=%b done=%b addr=%h wdata=%h want 1/1/1/0/%h/%h",
                         k, mem_e, mem_rw, busy, done, mem_addr, mem_wdata, 8'(8'h10 + k), wd[31-8*k -: 8]);
            end
        end
        @(negedge clk); #1;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || mem_e !== 1'b0) begin
            errors++; $display("FAIL wstore_done: done=%b busy=%b mem_e=%b want 1/0/0", done, busy, mem_e);
        end
        checks++;
        if ({ram[8'h10], ram[8'h11], ram[8'h12], ram[8'h13]} !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL wstore_ram: got %h%h%h%h want deadbeef", ram[8'h10], ram[8'h11], ram[8'h12], ram[8'h13]);
        end
        @(negedge clk);
    endtask

    task automatic test_word_load();
        drive_req(1'b0, 1'b1, 8'h10, 32'h0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k == 0) req_valid = 1'b0;
            #1;
            checks++;
            if (mem_e !== 1'b1 || mem_rw !== 1'b0 || mem_addr !== 8'(8'h10 + k)) begin
                errors++;
                $display("FAIL wload_xfer%0d: e=%b rw=%b addr=%h want 1/0/%h", k, mem_e, mem_rw, mem_addr, 8'(8'h10 + k));
            end
        end
        @(negedge clk); #1;
        checks++;
        if (done !== 1'b1 || rdata !== 32'hDEADBEEF) begin
            errors++; $display("FAIL wload_done: done=%b rdata=%h want 1/deadbeef", done, rdata);
        end
        @(negedge clk); #1;
        checks++;
        if (done !== 1'b0 || rdata !== 32'hDEADBEEF) begin
            errors++; $display("FAIL wload_hold: done=%b rdata=%h want 0/deadbeef", done, rdata);
        end
    endtask

    task automatic test_byte_access();
        drive_req(1'b0, 1'b0, 8'h12, 32'h0);
        @(negedge clk); req_valid = 1'b0; #1;
        checks++;
        if (mem_e !== 1'b1 || mem_addr !== 8'h12 || busy !== 1'b1) begin
            errors++; $display("FAIL bload_xfer: e=%b addr=%h busy=%b want 1/12/1", mem_e, mem_addr, busy);
        end
        @(negedge clk); #1;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || rdata !== 32'h000000BE) begin
            errors++; $display("FAIL bload_done: done=%b busy=%b rdata=%h want 1/0/000000be", done, busy, rdata);
        end
        @(negedge clk);
        drive_req(1'b1, 1'b0, 8'h20, 32'h12345677);
        @(negedge clk); req_valid = 1'b0; #1;
        checks++;
        if (mem_e !== 1'b1 || mem_rw !== 1'b1 || mem_addr !== 8'h20 || mem_wdata !== 8'h77) begin
            errors++;
            $display("FAIL bstore_xfer: e=%b rw=%b addr=%h wdata=%h want 1/1/20/77", mem_e, mem_rw, mem_addr, mem_wdata);
        end
        @(negedge clk); #1;
        checks++;
        if (done !== 1'b1 || ram[8'h20] !== 8'h77 || rdata !== 32'h000000BE) begin
            errors++;
            $display("FAIL bstore_done: done=%b ram20=%h rdata=%h want 1/77/000000be", done, ram[8'h20], rdata);
        end
        @(negedge clk);
    endtask

    task automatic test_misaligned();
        drive_req(1'b0, 1'b1, 8'h11, 32'h0); #1;
        checks++;
        if (err !== 1'b1 || done !== 1'b1 || busy !== 1'b0 || mem_e !== 1'b0 || rdata !== 32'h0) begin
            errors++;
            $display("FAIL misaligned_pulse: err=%b done=%b busy=%b mem_e=%b rdata=%h want 1/1/0/0/0",
                     err, done, busy, mem_e, rdata);
        end
        @(negedge clk); req_valid = 1'b0; #1;
        checks++;
        if (err !== 1'b0 || done !== 1'b0 || mem_e !== 1'b0 || busy !== 1'b0 || rdata !== 32'h0) begin
            errors++;
            $display("FAIL misaligned_after: err=%b done=%b mem_e=%b busy=%b rdata=%h want 0/0/0/0/0",
                     err, done, mem_e, busy, rdata);
        end
    endtask

    task automatic test_back_to_back();
        drive_req(1'b0, 1'b0, 8'h13, 32'h0);
        @(negedge clk);
        @(negedge clk); #1;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || mem_e !== 1'b0 || rdata !== 32'h000000EF) begin
            errors++;
            $display("FAIL b2b_done: done=%b busy=%b mem_e=%b rdata=%h want 1/0/0/000000ef", done, busy, mem_e, rdata);
        end
        @(negedge clk); #1;
        checks++;
        if (busy !== 1'b1 || mem_e !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL b2b_resample: busy=%b mem_e=%b done=%b want 1/0/0", busy, mem_e, done);
        end
        @(negedge clk); req_valid = 1'b0; #1;
        checks++;
        if (mem_e !== 1'b1 || mem_addr !== 8'h13) begin
            errors++; $display("FAIL b2b_second_xfer: mem_e=%b addr=%h want 1/13", mem_e, mem_addr);
        end
        @(negedge clk); @(negedge clk);
    endtask

    task automatic test_wrap_top();
        drive_req(1'b1, 1'b1, 8'hFC, 32'h01020304);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k == 0) req_valid = 1'b0;
            #1;
            checks++;
            if (mem_addr !== 8'(8'hFC + k) || mem_wdata !== 8'(k + 1)) begin
                errors++;
                $display("FAIL top_xfer%0d: addr=%h wdata=%h want %h/%h", k, mem_addr, mem_wdata, 8'(8'hFC + k), 8'(k + 1));
            end
        end
        @(negedge clk); #1;
        checks++;
        if (done !== 1'b1 || ram[8'hFF] !== 8'h04 || ram[8'hFC] !== 8'h01) begin
            errors++; $display("FAIL top_done: done=%b ramFC=%h ramFF=%h want 1/01/04", done, ram[8'hFC], ram[8'hFF]);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_xfer();
        drive_req(1'b1, 1'b1, 8'h40, 32'hA5A5A5A5);
        @(negedge clk); req_valid = 1'b0;
        repeat (5) @(negedge clk);
        drive_req(1'b1, 1'b1, 8'h40, 32'h11223344);
        @(negedge clk); req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        R = 1'b0; #1;
        checks++;
        if (mem_e !== 1'b0 || mem_rw !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
            mem_addr !== 8'h00 || mem_wdata !== 8'h00 || rdata !== 32'h0) begin
            errors++;
            $display("FAIL midreset_outputs: e=%b rw=%b busy=%b done=%b addr=%h wdata=%h rdata=%h want all 0",
                     mem_e, mem_rw, busy, done, mem_addr, mem_wdata, rdata);
        end
        @(negedge clk); #1;
        checks++;
        if ({ram[8'h40], ram[8'h41], ram[8'h42], ram[8'h43]} !== 32'h1122A5A5) begin
            errors++;
            $display("FAIL midreset_ram: got %h%h%h%h want 1122a5a5", ram[8'h40], ram[8'h41], ram[8'h42], ram[8'h43]);
        end
        R = 1'b1;
        @(negedge clk);
        drive_req(1'b0, 1'b0, 8'h42, 32'h0);
        @(negedge clk); req_valid = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (done !== 1'b1 || rdata !== 32'h000000A5) begin
            errors++; $display("FAIL midreset_fresh: done=%b rdata=%h want 1/000000a5", done, rdata);
        end
        @(negedge clk);
    endtask

    initial begin
        R = 1'b0;
        req_valid = 1'b0; req_rw = 1'b0; req_size = 1'b0; req_addr = 8'h00; req_wdata = 32'h0;
        test_reset();
        test_word_store();
        test_word_load();
        test_byte_access();
        test_misaligned();
        test_back_to_back();
        test_wrap_top();
        test_reset_mid_xfer();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
